// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access type codes, IO window select,
// requester ownership and helpers that classify an access.
package mem_ctrl_pkg;

  localparam logic [2:0] INSTY_LB  = 3'b000;
  localparam logic [2:0] INSTY_LH  = 3'b001;
  localparam logic [2:0] INSTY_LW  = 3'b010;
  localparam logic [2:0] INSTY_LBU = 3'b011;
  localparam logic [2:0] INSTY_LHU = 3'b100;
  localparam logic [2:0] INSTY_SB  = 3'b101;
  localparam logic [2:0] INSTY_SH  = 3'b110;
  localparam logic [2:0] INSTY_SW  = 3'b111;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  typedef enum logic {
    OWN_LS = 1'b0,
    OWN_IF = 1'b1
  } owner_t;

  function automatic logic is_store(input logic [2:0] insty);
    return insty[2] && (insty[1:0] != 2'b00);
  endfunction

  // Number of byte beats; fetches reuse the LW code so they are 4 beats too.
  function automatic logic [2:0] access_len(input logic [2:0] insty);
    case (insty)
      INSTY_LB, INSTY_LBU, INSTY_SB: access_len = 3'd1;
      INSTY_LH, INSTY_LHU, INSTY_SH: access_len = 3'd2;
      default:                       access_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the load-store buffer, the fetch unit, the byte-wide
// RAM/IO bus and the memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              ls_valid;
  logic [2:0]        ls_insty;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;

  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport master (
    output ls_valid, ls_insty, ls_addr, ls_wdata, if_valid, if_addr, mem_din, io_buffer_full,
    input  ls_done, ls_rdata, if_done, if_inst, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  ls_valid, ls_insty, ls_addr, ls_wdata, if_valid, if_addr, mem_din, io_buffer_full,
    output ls_done, ls_rdata, if_done, if_inst, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl_load_extend.sv
// Turns the assembled little-endian load bytes into the architectural register value.
module mem_ctrl_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  insty,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (insty)
      INSTY_LB:  data = {{24{raw[7]}}, raw[7:0]};
      INSTY_LH:  data = {{16{raw[15]}}, raw[15:0]};
      INSTY_LBU: data = {24'd0, raw[7:0]};
      INSTY_LHU: data = {16'd0, raw[15:0]};
      default:   data = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates load/store and fetch requests onto the byte-wide RAM/IO bus, serialising
// each access into byte beats and returning one-cycle completion pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    jump_wrong,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]        state;
  owner_t            owner;
  logic [2:0]        k;
  logic [2:0]        len;
  logic [2:0]        insty;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;
  logic [31:0]       asm_word;
  logic [31:0]       ext_word;
  logic              ls_done_q;
  logic              if_done_q;
  logic [31:0]       ls_rdata_q;
  logic [31:0]       if_inst_q;

  logic take_ls;
  logic take_if;
  logic io_hold;
  logic flush;

  assign take_ls = rdy && (state == ST_IDLE) && bus.ls_valid;
  assign take_if = rdy && (state == ST_IDLE) && !bus.ls_valid && bus.if_valid && !jump_wrong;
  assign io_hold = (addr[17:16] == IO_SEL) && bus.io_buffer_full;
  assign flush   = jump_wrong && (owner == OWN_IF) && (state != ST_IDLE);

  assign bus.ls_done  = ls_done_q;
  assign bus.if_done  = if_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.if_inst  = if_inst_q;

  // While frozen in READ, re-address the byte still owed so mem_din is valid on resume.
  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take_ls && !is_store(bus.ls_insty)) bus.mem_a = bus.ls_addr;
        else if (take_if)                       bus.mem_a = bus.if_addr;
      end
      ST_READ: begin
        if (!rdy)         bus.mem_a = addr + ADDR_W'(k - 3'd1);
        else if (k < len) bus.mem_a = addr + ADDR_W'(k);
      end
      ST_WRITE: begin
        bus.mem_a    = addr + ADDR_W'(k);
        bus.mem_dout = wdata[{k[1:0], 3'b000} +: 8];
        bus.mem_wr   = rdy && !io_hold;
      end
      default: ;
    endcase
  end

  always_comb begin
    asm_word = rbuf;
    case (k)
      3'd1: asm_word[7:0]   = bus.mem_din;
      3'd2: asm_word[15:8]  = bus.mem_din;
      3'd3: asm_word[23:16] = bus.mem_din;
      3'd4: asm_word[31:24] = bus.mem_din;
      default: ;
    endcase
  end

  mem_ctrl_load_extend u_extend (
    .insty (insty),
    .raw   (asm_word),
    .data  (ext_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_LS;
      k          <= '0;
      len        <= '0;
      insty      <= '0;
      addr       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      ls_done_q  <= 1'b0;
      if_done_q  <= 1'b0;
      ls_rdata_q <= '0;
      if_inst_q  <= '0;
    end else if (rdy) begin
      ls_done_q <= 1'b0;
      if_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_ls || take_if) begin
            owner <= take_ls ? OWN_LS : OWN_IF;
            insty <= take_ls ? bus.ls_insty : INSTY_LW;
            addr  <= take_ls ? bus.ls_addr : bus.if_addr;
            wdata <= bus.ls_wdata;
            len   <= access_len(take_ls ? bus.ls_insty : INSTY_LW);
            if (take_ls && is_store(bus.ls_insty)) begin
              state <= ST_WRITE;
              k     <= 3'd0;
            end else begin
              state <= ST_READ;
              k     <= 3'd1;
            end
          end
        end
        ST_READ: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            rbuf <= asm_word;
            if (k == len) begin
              state <= ST_IDLE;
              if (owner == OWN_LS) begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= ext_word;
              end else begin
                if_done_q <= 1'b1;
                if_inst_q <= asm_word;
              end
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          if (!io_hold) begin
            if (k == 3'(len - 3'd1)) begin
              state     <= ST_IDLE;
              ls_done_q <= 1'b1;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of loads plus hand-written store, arbitration,
// mispredict and stall sequences against a 256-byte RAM model with 1-cycle read latency.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic jump_wrong;
  int   checks = 0;
  int   errors = 0;

  mem_ctrl_if #(.ADDR_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jump_wrong (jump_wrong),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:255];

  function automatic logic [7:0] initByte(input int i);
    case (i)
      0:   return 8'h78;
      1:   return 8'h56;
      2:   return 8'h34;
      3:   return 8'h12;
      16:  return 8'h80;
      20:  return 8'h01;
      21:  return 8'h80;
      22:  return 8'hEF;
      23:  return 8'hBE;
      254: return 8'hAA;
      255: return 8'hBB;
      default: return 8'h00;
    endcase
  endfunction

  // RAM model: loaded while in reset, IO window writes are not stored.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= initByte(i);
    end else begin
      bus.mem_din <= ram[bus.mem_a[7:0]];
      if (bus.mem_wr && bus.mem_a[17:16] != 2'b11) ram[bus.mem_a[7:0]] <= bus.mem_dout;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectBus(input string tag, input logic done, input logic wr,
                           input logic [31:0] a, input logic [7:0] d);
    logic [63:0] act;
    logic [63:0] exp;
    @(negedge clk);
    exp = {22'd0, done, wr, wr ? {d, a} : 40'd0};
    act = {22'd0, bus.ls_done, bus.mem_wr, wr ? {bus.mem_dout, bus.mem_a} : 40'd0};
    checkOutput(tag, act, exp);
  endtask

  task automatic applyStimulus(input logic [2:0] insty, input logic [31:0] addr, input int rdyOff,
                               input int jwAt, output logic [31:0] data, output int lat);
    lat  = -1;
    data = '0;
    @(posedge clk); #1;
    bus.ls_valid = 1'b1;
    bus.ls_insty = insty;
    bus.ls_addr  = addr;
    for (int c = 0; c < 16 && lat < 0; c++) begin
      rdy        = !(rdyOff >= 0 && (c == rdyOff || c == rdyOff + 1));
      jump_wrong = (c == jwAt);
      @(negedge clk);
      if (bus.ls_done) begin
        lat  = c;
        data = bus.ls_rdata;
        bus.ls_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    rdy          = 1'b1;
    jump_wrong   = 1'b0;
    bus.ls_valid = 1'b0;
  endtask

  task automatic runFetch(input logic [31:0] addr, input int jwAt, input logic [31:0] newAddr,
                          output logic [31:0] inst, output int lat);
    lat  = -1;
    inst = '0;
    @(posedge clk); #1;
    bus.if_valid = 1'b1;
    bus.if_addr  = addr;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      jump_wrong = (c == jwAt);
      if (c == jwAt) bus.if_addr = newAddr;
      @(negedge clk);
      if (bus.if_done) begin
        lat  = c;
        inst = bus.if_inst;
        bus.if_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    jump_wrong   = 1'b0;
    bus.if_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  insty;
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } load_vec_t;

  load_vec_t   vecs [10];
  logic [31:0] got;
  logic [31:0] got_if;
  int          lat;
  int          ls_lat;
  int          if_lat;
  int          both;

  initial begin
    vecs[0] = '{INSTY_LW,  32'h0000_0100, 32'h1234_5678, 5};
    vecs[1] = '{INSTY_LB,  32'h0000_0010, 32'hFFFF_FF80, 2};
    vecs[2] = '{INSTY_LBU, 32'h0000_0010, 32'h0000_0080, 2};
    vecs[3] = '{INSTY_LH,  32'h0000_0014, 32'hFFFF_8001, 3};
    vecs[4] = '{INSTY_LHU, 32'h0000_0014, 32'h0000_8001, 3};
    vecs[5] = '{INSTY_LW,  32'h0000_0014, 32'hBEEF_8001, 5};
    vecs[6] = '{INSTY_LB,  32'h0000_0016, 32'hFFFF_FFEF, 2};
    vecs[7] = '{INSTY_LH,  32'h0000_0100, 32'h0000_5678, 3};
    vecs[8] = '{INSTY_LW,  32'hFFFF_FFFE, 32'h5678_BBAA, 5};
    vecs[9] = '{INSTY_LBU, 32'h0000_0017, 32'h0000_00BE, 2};

    rst = 1'b1;
    rdy = 1'b1;
    jump_wrong = 1'b0;
    bus.ls_valid = 1'b0;
    bus.ls_insty = '0;
    bus.ls_addr  = '0;
    bus.ls_wdata = '0;
    bus.if_valid = 1'b0;
    bus.if_addr  = '0;
    bus.io_buffer_full = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ls_done",  64'(bus.ls_done),  64'd0);
    checkOutput("rst_if_done",  64'(bus.if_done),  64'd0);
    checkOutput("rst_ls_rdata", 64'(bus.ls_rdata), 64'd0);
    checkOutput("rst_if_inst",  64'(bus.if_inst),  64'd0);
    checkOutput("rst_mem_a",    64'(bus.mem_a),    64'd0);
    checkOutput("rst_mem_dout", 64'(bus.mem_dout), 64'd0);
    checkOutput("rst_mem_wr",   64'(bus.mem_wr),   64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].insty, vecs[i].addr, -1, -1, got, lat);
      checkOutput($sformatf("load%0d_data", i), 64'(got), 64'(vecs[i].data));
      checkOutput($sformatf("load%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    runFetch(32'h100, -1, 32'h0, got_if, if_lat);
    checkOutput("fetch_inst", 64'(got_if), 64'h1234_5678);
    checkOutput("fetch_lat",  64'(if_lat), 64'd5);

    // Both requesters at once: the load goes first, the fetch is taken in its done cycle.
    @(posedge clk); #1;
    bus.ls_valid = 1'b1;
    bus.ls_insty = INSTY_LW;
    bus.ls_addr  = 32'h100;
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h14;
    ls_lat = -1;
    if_lat = -1;
    both   = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.ls_done && bus.if_done) both++;
      if (bus.ls_done && ls_lat < 0) begin
        ls_lat = c;
        got    = bus.ls_rdata;
        bus.ls_valid = 1'b0;
      end
      if (bus.if_done && if_lat < 0) begin
        if_lat = c;
        got_if = bus.if_inst;
        bus.if_valid = 1'b0;
      end
    end
    bus.ls_valid = 1'b0;
    bus.if_valid = 1'b0;
    checkOutput("arb_ls_lat",  64'(ls_lat), 64'd5);
    checkOutput("arb_ls_data", 64'(got),    64'h1234_5678);
    checkOutput("arb_if_lat",  64'(if_lat), 64'd10);
    checkOutput("arb_if_inst", 64'(got_if), 64'hBEEF_8001);
    checkOutput("arb_both",    64'(both),   64'd0);

    runFetch(32'h0, 4, 32'h14, got_if, if_lat);
    checkOutput("jw_if_lat",  64'(if_lat), 64'd10);
    checkOutput("jw_if_inst", 64'(got_if), 64'hBEEF_8001);

    applyStimulus(INSTY_LW, 32'h100, -1, 2, got, lat);
    checkOutput("jw_ls_data", 64'(got), 64'h1234_5678);
    checkOutput("jw_ls_lat",  64'(lat), 64'd5);

    applyStimulus(INSTY_LW, 32'h100, 2, -1, got, lat);
    checkOutput("stall_ld_data", 64'(got), 64'h1234_5678);
    checkOutput("stall_ld_lat",  64'(lat), 64'd7);

    @(posedge clk); #1;
    bus.ls_valid = 1'b1;
    bus.ls_insty = INSTY_SH;
    bus.ls_addr  = 32'h20;
    bus.ls_wdata = 32'h1234_ABCD;
    expectBus("sh_c0", 1'b0, 1'b0, 32'h0, 8'h00);
    expectBus("sh_c1", 1'b0, 1'b1, 32'h20, 8'hCD);
    expectBus("sh_c2", 1'b0, 1'b1, 32'h21, 8'hAB);
    expectBus("sh_c3", 1'b1, 1'b0, 32'h0, 8'h00);
    bus.ls_valid = 1'b0;
    expectBus("sh_c4", 1'b0, 1'b0, 32'h0, 8'h00);

    @(posedge clk); #1;
    bus.io_buffer_full = 1'b1;
    bus.ls_valid = 1'b1;
    bus.ls_insty = INSTY_SB;
    bus.ls_addr  = 32'h0003_0000;
    bus.ls_wdata = 32'h0000_0077;
    expectBus("io_c0", 1'b0, 1'b0, 32'h0, 8'h00);
    expectBus("io_c1", 1'b0, 1'b0, 32'h0, 8'h00);
    expectBus("io_c2", 1'b0, 1'b0, 32'h0, 8'h00);
    expectBus("io_c3", 1'b0, 1'b0, 32'h0, 8'h00);
    @(posedge clk); #1;
    bus.io_buffer_full = 1'b0;
    expectBus("io_c4", 1'b0, 1'b1, 32'h0003_0000, 8'h77);
    expectBus("io_c5", 1'b1, 1'b0, 32'h0, 8'h00);
    bus.ls_valid = 1'b0;

    // Buffer full must not stall a store outside the IO window.
    @(posedge clk); #1;
    bus.io_buffer_full = 1'b1;
    bus.ls_valid = 1'b1;
    bus.ls_insty = INSTY_SB;
    bus.ls_addr  = 32'h0002_0040;
    bus.ls_wdata = 32'h0000_0055;
    expectBus("nio_c0", 1'b0, 1'b0, 32'h0, 8'h00);
    expectBus("nio_c1", 1'b0, 1'b1, 32'h0002_0040, 8'h55);
    expectBus("nio_c2", 1'b1, 1'b0, 32'h0, 8'h00);
    bus.ls_valid = 1'b0;
    bus.io_buffer_full = 1'b0;

    @(posedge clk); #1;
    bus.ls_valid = 1'b1;
    bus.ls_insty = INSTY_SB;
    bus.ls_addr  = 32'h41;
    bus.ls_wdata = 32'h0000_005A;
    expectBus("rdy_c0", 1'b0, 1'b0, 32'h0, 8'h00);
    @(posedge clk); #1;
    rdy = 1'b0;
    expectBus("rdy_c1", 1'b0, 1'b0, 32'h0, 8'h00);
    @(posedge clk); #1;
    rdy = 1'b1;
    expectBus("rdy_c2", 1'b0, 1'b1, 32'h41, 8'h5A);
    expectBus("rdy_c3", 1'b1, 1'b0, 32'h0, 8'h00);
    bus.ls_valid = 1'b0;

    @(posedge clk); #1;
    checkOutput("ram_20", 64'(ram[8'h20]), 64'hCD);
    checkOutput("ram_21", 64'(ram[8'h21]), 64'hAB);
    checkOutput("ram_40", 64'(ram[8'h40]), 64'h55);
    checkOutput("ram_41", 64'(ram[8'h41]), 64'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
